// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC issue, in-order prefetch FIFO, flush on redirect.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect parks fetch in HALT and raises fetch_misaligned.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        fetch_misaligned
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

`ifdef FETCH_MISALIGN_CHECK_EN
   typedef enum logic [1:0] {IDLE, FETCH, FLUSH, HALT} state_t;
`else
   typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
`endif

   state_t                      state, state_nxt, resume, redir_resume;
   logic [31:0]                 fetch_pc, rsp_pc, new_pc;
   logic [CW-1:0]               outstanding, out_nxt, drop, drop_nxt, count;
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic [FIFO_DEPTH-1:0][31:0] mem_data, mem_pc;
   logic                        req_fire, push, pop, rsp_discard;

   assign new_pc = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
   logic mis_q, mis_new;
   assign mis_new = redirect_pc[1:0] != 2'b00;

   always_ff @(posedge clk or posedge rst)
      if (rst)                 mis_q <= 1'b0;
      else if (redirect_valid) mis_q <= mis_new;

   assign fetch_misaligned = mis_q;
   // mis_q remembers where to land once the stale responses have drained
   assign resume       = mis_q   ? HALT : FETCH;
   assign redir_resume = mis_new ? HALT : FETCH;
`else
   wire unused_pc_lsbs = ^redirect_pc[1:0];
   assign resume       = FETCH;
   assign redir_resume = FETCH;
`endif

   assign req_fire    = imem_req_valid && imem_req_ready;
   assign rsp_discard = imem_rsp_valid && (drop != '0);
   assign push        = imem_rsp_valid && (drop == '0) && !redirect_valid;
   assign pop         = instr_valid && instr_ready && !redirect_valid;
   assign out_nxt     = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

   // credit: buffered words plus words in flight never exceed the FIFO
   assign imem_req_valid = (state == FETCH) &&
                           ((CW+1)'(count) + (CW+1)'(outstanding) < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = fetch_pc;

   assign instr_valid = count != '0;
   assign instruction = mem_data[rd_ptr];
   assign instr_pc    = mem_pc[rd_ptr];

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nxt;

   always_comb begin
      state_nxt = state;
      drop_nxt  = drop - CW'(rsp_discard);
      case (state)
         IDLE:    state_nxt = FETCH;
         FLUSH:   if (drop_nxt == '0) state_nxt = resume;
         default: state_nxt = state;
      endcase
      // everything still in flight after this cycle belongs to the old stream
      if (redirect_valid) begin
         drop_nxt  = out_nxt;
         state_nxt = (out_nxt != '0) ? FLUSH : redir_resume;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= out_nxt;
         drop        <= drop_nxt;
         if (redirect_valid) begin
            fetch_pc <= new_pc;
            rsp_pc   <= new_pc;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (push)     rsp_pc   <= rsp_pc + 32'd4;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         mem_data <= '0;
         mem_pc   <= '0;
      end else if (redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= imem_rsp_data;
            mem_pc[wr_ptr]   <= rsp_pc;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(push && count == CW'(FIFO_DEPTH)));
   assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && outstanding == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order variable-latency memory model plus
// stream checks on request addresses and delivered {pc, instruction}.
`timescale 1ns/1ps
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid, instr_ready;
   logic [31:0] instruction, instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fetch_misaligned;
`endif

   fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .instr_pc(instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
      , .fetch_misaligned(fetch_misaligned)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] data; int due; } rsp_t;
   rsp_t        mq[$];
   int          cyc, lat, nchk, nerr, n_req, n_del, base;
   logic [31:0] exp_req, exp_pc, stall_addr;
   logic        stall_pend, found;
   logic [15:0] rpat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return ~a;
   endfunction

   // one clock: called at a negedge, drives memory, checks, returns at the next negedge
   task automatic cycle();
      rsp_t r;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         r = mq.pop_front();
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = r.data;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
      if (stall_pend) begin
         check("hold_valid", 32'(imem_req_valid), 32'd1);
         check("hold_addr", imem_req_addr, stall_addr);
      end
      stall_pend = imem_req_valid && !imem_req_ready;
      stall_addr = imem_req_addr;
      if (imem_req_valid && imem_req_ready) begin
         check("req_addr", imem_req_addr, exp_req);
         r.data = word_of(imem_req_addr);
         r.due  = cyc + lat;
         mq.push_back(r);
         exp_req += 32'd4;
         n_req++;
      end
      if (instr_valid && instr_ready && !redirect_valid) begin
         check("instr_pc", instr_pc, exp_pc);
         check("instruction", instruction, word_of(exp_pc));
         exp_pc += 32'd4;
         n_del++;
      end
      @(posedge clk);
      if (redirect_valid) begin
         exp_req    = {redirect_pc[31:2], 2'b00};
         exp_pc     = exp_req;
         stall_pend = 1'b0;
      end
      @(negedge clk);
      redirect_valid = 1'b0;
      cyc++;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b1;
      repeat (2) @(negedge clk);
      mq.delete();
      cyc = 0; exp_req = '0; exp_pc = '0; stall_pend = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nchk = 0; nerr = 0; n_req = 0; n_del = 0; lat = 1; cyc = 0;
      exp_req = '0; exp_pc = '0; stall_pend = 1'b0; found = 1'b0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
      #1 rst = 1'b1;
      #2;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_req_addr", imem_req_addr, 32'h0);
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_instruction", instruction, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif

      // sequential stream, 1-cycle memory
      do_reset();
      check("idle_no_req", 32'(imem_req_valid), 32'd0);
      cycle();
      check("first_req_valid", 32'(imem_req_valid), 32'd1);
      check("first_req_addr", imem_req_addr, 32'h0);
      base = n_del;
      repeat (19) cycle();
      check("t1_throughput", 32'(n_del - base >= 10), 32'd1);

      // core stalled: FIFO fills to depth, then drains in order
      do_reset();
      instr_ready = 1'b0;
      base = n_req;
      repeat (10) cycle();
      check("t2_req_count", n_req - base, 32'd2);
      check("t2_full_no_req", 32'(imem_req_valid), 32'd0);
      check("t2_head_valid", 32'(instr_valid), 32'd1);
      check("t2_head_pc", instr_pc, 32'h0);
      check("t2_head_instr", instruction, 32'hFFFF_FFFF);
      instr_ready = 1'b1;
      base = n_del;
      repeat (8) cycle();
      check("t2_drain", 32'(n_del - base >= 2), 32'd1);

      // memory back-pressure
      rpat = 16'b1011_0010_0110_1001;
      base = n_del;
      for (int i = 0; i < 16; i++) begin
         imem_req_ready = rpat[i];
         cycle();
      end
      imem_req_ready = 1'b1;
      check("t3_progress", 32'(n_del - base >= 3), 32'd1);

      // 3-cycle memory, redirect with two requests in flight
      do_reset();
      lat = 3;
      repeat (3) cycle();
      check("t4_credit_stall", 32'(imem_req_valid), 32'd0);
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      cycle();
      check("t4_flush_c4", 32'(imem_req_valid), 32'd0);
      cycle();
      check("t4_flush_c5", 32'(imem_req_valid), 32'd0);
      cycle();
      check("t4_resume_valid", 32'(imem_req_valid), 32'd1);
      check("t4_resume_addr", imem_req_addr, 32'h100);
      repeat (3) cycle();
      check("t4_no_bypass", 32'(instr_valid), 32'd0);
      cycle();
      check("t4_first_valid", 32'(instr_valid), 32'd1);
      check("t4_first_pc", instr_pc, 32'h100);

      // redirect colliding with a push and a pop
      lat = 1;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (mq.size() > 0 && mq[0].due <= cyc && instr_valid) found = 1'b1;
         else cycle();
      end
      check("t5_found", 32'(found), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      cycle();
      check("t5_empty", 32'(instr_valid), 32'd0);
      base = n_del;
      repeat (12) cycle();
      check("t5_progress", 32'(n_del - base >= 4), 32'd1);

      // PC wraps past the top of the address space
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      cycle();
      base = n_del;
      repeat (12) cycle();
      check("wrap_progress", 32'(n_del - base >= 4), 32'd1);

`ifdef FETCH_MISALIGN_CHECK_EN
      redirect_valid = 1'b1; redirect_pc = 32'h102;
      cycle();
      check("mis_flag", 32'(fetch_misaligned), 32'd1);
      base = n_req;
      repeat (8) cycle();
      check("mis_no_req", n_req - base, 32'd0);
      check("mis_flag_hold", 32'(fetch_misaligned), 32'd1);
      redirect_valid = 1'b1; redirect_pc = 32'h104;
      cycle();
      check("mis_clear", 32'(fetch_misaligned), 32'd0);
      base = n_del;
      repeat (8) cycle();
      check("mis_resume", 32'(n_del - base >= 2), 32'd1);
`endif

      // asynchronous reset in the middle of a cycle
      repeat (2) cycle();
      #2 rst = 1'b1;
      #1;
      check("arst_req_valid", 32'(imem_req_valid), 32'd0);
      check("arst_req_addr", imem_req_addr, 32'h0);
      check("arst_instr_valid", 32'(instr_valid), 32'd0);
      check("arst_instr_pc", instr_pc, 32'h0);
      check("arst_instruction", instruction, 32'h0);
      @(negedge clk);
      do_reset();
      base = n_del;
      repeat (6) cycle();
      check("post_rst_progress", 32'(n_del - base >= 2), 32'd1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
